// File: rtl/rca_serial_wide_adder_pkg.sv
// Shared definitions for the byte-serial wide adder sequencer.
// State encoding and the constant used for the second-pass carry increment.
package rca_serial_wide_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [BYTE_W-1:0] INC_OPERAND = 8'h01;

endpackage

// File: rtl/ripple_carry_adder.sv
// 8-bit ripple-carry adder with no carry-in; purely combinational.
// Lives beside the sequencer and is wired to its rca_* ports.
module RippleCarryAdder (
  input  logic [7:0] i0,
  input  logic [7:0] i1,
  output logic [7:0] o,
  output logic       cout
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    o    = '0;
    for (int i = 0; i < 8; i++) begin
      o[i]   = i0[i] ^ i1[i] ^ c[i];
      c[i+1] = (i0[i] & i1[i]) | (c[i] & (i0[i] ^ i1[i]));
    end
    cout = c[8];
  end

endmodule

// File: rtl/rca_serial_wide_adder.sv
// Adds two NBYTES-wide operands one byte per pass through an external 8-bit adder.
// A byte that receives a carry takes a second pass adding 8'h01, since the adder has no carry-in.
module rca_serial_wide_adder
  import rca_serial_wide_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NBYTES*BYTE_W-1:0] a,
  input  logic [NBYTES*BYTE_W-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [NBYTES*BYTE_W-1:0] sum,
  output logic                     cout,
  output logic [BYTE_W-1:0]        rca_i0,
  output logic [BYTE_W-1:0]        rca_i1,
  input  logic [BYTE_W-1:0]        rca_o,
  input  logic                     rca_cout
);

  localparam int W     = NBYTES * BYTE_W;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  logic                c1_q;
  logic [BYTE_W-1:0]   partial_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        sum_q;
  logic                cout_q;
  logic                busy_q;
  logic                done_q;

  logic                byte_wr;
  logic                carry_d;

  always_comb begin
    rca_i0 = '0;
    rca_i1 = '0;
    case (state_q)
      ADD: begin
        rca_i0 = a_q[idx_q*BYTE_W +: BYTE_W];
        rca_i1 = b_q[idx_q*BYTE_W +: BYTE_W];
      end
      INC: begin
        rca_i0 = partial_q;
        rca_i1 = INC_OPERAND;
      end
      default: ;
    endcase
  end

  // A byte is final either on a carry-free ADD pass or after its INC pass.
  // c1 and the INC carry are mutually exclusive, so OR-ing them is exact.
  always_comb begin
    byte_wr = (state_q == INC) || ((state_q == ADD) && !carry_q);
    carry_d = (state_q == INC) ? (c1_q | rca_cout) : rca_cout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      c1_q      <= 1'b0;
      partial_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD, INC: begin
          if (byte_wr) begin
            sum_q[idx_q*BYTE_W +: BYTE_W] <= rca_o;
            carry_q <= carry_d;
            if (idx_q == LAST_IDX) begin
              cout_q  <= carry_d;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ADD;
            end
          end else begin
            partial_q <= rca_o;
            c1_q      <= rca_cout;
            state_q   <= INC;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_rca_serial_wide_adder.sv
// Bench for the byte-serial wide adder: directed cases then random operands,
// checked by a queue-based scoreboard against a plain-arithmetic reference.
module tb_rca_serial_wide_adder;

  localparam int NB = 4;
  localparam int W  = NB * 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [7:0]   rca_i0, rca_i1, rca_o;
  logic         rca_cout;

  rca_serial_wide_adder #(.NBYTES(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .rca_i0(rca_i0), .rca_i1(rca_i1), .rca_o(rca_o), .rca_cout(rca_cout)
  );

  RippleCarryAdder u_rca (
    .i0(rca_i0), .i1(rca_i1), .o(rca_o), .cout(rca_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected result from whole-word arithmetic; latency adds one cycle per byte
  // whose incoming carry (from the lower bytes' sum) is 1.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int t0);
    exp_t e;
    longint unsigned ax, bx, full, m;
    int k;
    ax = x;
    bx = y;
    full = ax + bx;
    k = 0;
    for (int i = 1; i < NB; i++) begin
      m = (64'd1 << (8 * i)) - 64'd1;
      if ((((ax & m) + (bx & m)) >> (8 * i)) != 0) k++;
    end
    e.s   = full[W-1:0];
    e.c   = full[W];
    e.lat = NB + 1 + k;
    e.t0  = t0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !busy) begin
      n_cmp++;
      if (rca_i0 !== 8'h00 || rca_i1 !== 8'h00) begin
        n_bad++;
        $display("FAIL idle_rca: i0=0x%0h i1=0x%0h expected 0", rca_i0, rca_i1);
      end
    end
    if (done === 1'b1) begin
      n_cmp++;
      if (done_prev) begin
        n_bad++;
        $display("FAIL done_width: done high on consecutive cycles, expected 1-cycle pulse");
      end
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done with no outstanding operation");
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (sum !== e.s) begin
          n_bad++;
          $display("FAIL sum: got 0x%08h expected 0x%08h", sum, e.s);
        end
        n_cmp++;
        if (cout !== e.c) begin
          n_bad++;
          $display("FAIL cout: got %0b expected %0b", cout, e.c);
        end
        n_cmp++;
        if (cyc - e.t0 != e.lat) begin
          n_bad++;
          $display("FAIL latency: got %0d expected %0d", cyc - e.t0, e.lat);
        end
      end
    end
    done_prev = done;
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y, cyc));
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: no done within budget", tag);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    issue(x, y);
    wait_drain(tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum",  64'(sum),  64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: no carries between bytes; result holds afterwards
    run_op(32'h12345678, 32'h11111111, "t1");
    repeat (5) @(negedge clk);
    chk("hold_sum",  64'(sum),  64'h23456789);
    chk("hold_cout", 64'(cout), 64'd0);

    // 2, 3: carry chains of length 1 and 3
    run_op(32'h000000FF, 32'h00000001, "t2");
    run_op(32'hFFFFFFFF, 32'h00000001, "t3");

    // 4: overflow, with a second start pulse while busy that must be ignored
    issue(32'h80000000, 32'h80000000);
    @(posedge clk); #1;
    a = 32'h01020304;
    b = 32'h05060708;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("t4");
    repeat (10) @(negedge clk);

    // 5: reset in the third busy cycle aborts without done
    @(posedge clk); #1;
    a = 32'hFFFFFFFF;
    b = 32'h00000001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_sum",  64'(sum),  64'd0);
    chk("t5_cout", 64'(cout), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_op(32'h00000001, 32'h00000001, "t5b");

    // 6: random operands, a quarter of them near the overflow point
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ~ra + W'($urandom_range(0, 2));
      run_op(ra, rb, "rand");
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
